// File: rtl/nonogram_pkg.sv
// Shared nonogram board constants and the serializer state type.
// Used by the parser, solver, assembler and top level.
package nonogram_pkg;

  localparam int MAX_ROWS = 11;
  localparam int MAX_COLS = 11;
  localparam int ROW_W    = $clog2(MAX_ROWS);
  localparam int COL_W    = $clog2(MAX_COLS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    FINISH
  } state_e;

endpackage

// File: rtl/solution_assembler_row_packer.sv
// Combinational row extractor: packs row r of the board into a
// right-aligned 16-bit word, column 0 in the most significant used bit.
module row_packer #(
  parameter int MAX_ROWS = nonogram_pkg::MAX_ROWS,
  parameter int MAX_COLS = nonogram_pkg::MAX_COLS
) (
  input  logic [MAX_ROWS*MAX_COLS-1:0] board_i,
  input  logic [$clog2(MAX_ROWS)-1:0]  row_i,
  input  logic [$clog2(MAX_COLS)-1:0]  n_i,
  output logic [15:0]                  word_o
);

  localparam int BW = $clog2(MAX_ROWS*MAX_COLS);

  always_comb begin
    word_o = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (c < int'(n_i) && int'(row_i) < MAX_ROWS) begin
        word_o[4'(int'(n_i) - 1 - c)] =
          board_i[BW'(int'(row_i) * MAX_COLS + c)];
      end
    end
  end

endmodule

// File: rtl/solution_assembler.sv
// Serializes a solved board for uart_tx: one header byte {m,n}
// followed by a high/low byte pair per row, each byte handshaked.
module solution_assembler #(
  parameter int MAX_ROWS = nonogram_pkg::MAX_ROWS,
  parameter int MAX_COLS = nonogram_pkg::MAX_COLS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         transmit_done,
  input  logic [MAX_ROWS*MAX_COLS-1:0] solution,
  input  logic [$clog2(MAX_ROWS)-1:0]  m,
  input  logic [$clog2(MAX_COLS)-1:0]  n,
  output logic                         send,
  output logic [7:0]                   byte_out,
  output logic                         done
);

  import nonogram_pkg::*;

  localparam int RW = $clog2(MAX_ROWS);
  localparam int CW = $clog2(MAX_COLS);
  localparam int IW = $clog2(2*MAX_ROWS+1);
  localparam int NB = MAX_ROWS*MAX_COLS;

  state_e        state_q;
  logic [NB-1:0] sol_q;
  logic [RW-1:0] m_q;
  logic [CW-1:0] n_q;
  logic [IW-1:0] idx_q;
  logic          send_q;
  logic          done_q;
  logic [7:0]    byte_q;

  logic [IW-1:0] off_d;
  logic [RW-1:0] row_d;
  logic [15:0]   word_d;
  logic [7:0]    byte_d;
  logic          last_d;

  // Byte k>0 carries row (k-1)/2; even offsets are the high half.
  assign off_d  = idx_q - IW'(1);
  assign row_d  = RW'(off_d >> 1);
  assign last_d = (idx_q == IW'({m_q, 1'b0}));

  row_packer #(
    .MAX_ROWS(MAX_ROWS),
    .MAX_COLS(MAX_COLS)
  ) u_row_packer (
    .board_i(sol_q),
    .row_i  (row_d),
    .n_i    (n_q),
    .word_o (word_d)
  );

  always_comb begin
    byte_d = '0;
    unique case (1'b1)
      (idx_q == '0):     byte_d = {4'(m_q), 4'(n_q)};
      (off_d[0] == 1'b0): byte_d = word_d[15:8];
      default:           byte_d = word_d[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sol_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            sol_q   <= solution;
            m_q     <= m;
            n_q     <= n;
            idx_q   <= '0;
            state_q <= (m == '0 || n == '0) ? FINISH : LOAD;
          end
        end
        LOAD: begin
          byte_q  <= byte_d;
          send_q  <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          // An acknowledge in the same cycle as send is stale.
          if (transmit_done && !send_q) begin
            if (last_d) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= LOAD;
            end
          end
        end
        FINISH: begin
          // Empty boards pulse done here; full transfers already did.
          done_q  <= !done_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign send     = send_q;
  assign done     = done_q;
  assign byte_out = byte_q;

endmodule

// File: tb/tb_solution_assembler.sv
// Scoreboard bench for solution_assembler: directed boards plus
// random boards checked against a cell-level reference model.
module tb_solution_assembler;

  localparam int R  = 11;
  localparam int C  = 11;
  localparam int NB = R*C;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic          transmit_done = 1'b0;
  logic [NB-1:0] solution = '0;
  logic [3:0]    m = '0;
  logic [3:0]    n = '0;
  logic          send;
  logic          done;
  logic [7:0]    byte_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_done;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bytes[$];

  always #10 clk = ~clk;

  solution_assembler #(
    .MAX_ROWS(R),
    .MAX_COLS(C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .transmit_done(transmit_done),
    .solution     (solution),
    .m            (m),
    .n            (n),
    .send         (send),
    .byte_out     (byte_out),
    .done         (done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every send/done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (send || done)) begin
      checks++;
      if (send && done) begin
        errors++;
        $display("FAIL send_and_done: got both, required one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got send=%0b done=%0b, required none",
                 send, done);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done != done || (send && byte_out !== e.val)) begin
          errors++;
          $display("FAIL stream: got send=%0b done=%0b byte=%h, required done=%0b byte=%h",
                   send, done, byte_out, e.is_done, e.val);
        end
      end
    end
  end

  // Reference: header {m,n}, then each row's cells shifted in MSB first.
  task automatic model(input logic [NB-1:0] sol, input int mm,
                       input int nn);
    int w;
    bytes.delete();
    bytes.push_back(8'(mm*16 + nn));
    for (int r = 0; r < mm; r++) begin
      w = 0;
      for (int c = 0; c < nn; c++) w = w*2 + int'(sol[r*C+c]);
      bytes.push_back(8'(w / 256));
      bytes.push_back(8'(w % 256));
    end
  endtask

  task automatic quiet(input string name, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (send || done) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  task automatic run_board(input logic [NB-1:0] sol, input int mm,
                           input int nn, input int dly, input bit coinc,
                           input bit revalid, input int abort_at);
    int lat;
    int nb;
    int d;
    bit zero;
    zero = (mm == 0 || nn == 0);
    nb = zero ? 0 : bytes.size();
    for (int i = 0; i < nb; i++) exp_q.push_back('{1'b0, bytes[i]});
    exp_q.push_back('{1'b1, 8'h00});
    solution = sol;
    m = 4'(mm);
    n = 4'(nn);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    solution = ~sol;
    m = 4'($urandom);
    n = 4'($urandom);
    if (zero) begin
      tick();
      chk("zero_done_lat", done, 1);
      chk("zero_no_send", send, 0);
      tick();
      return;
    end
    for (int k = 0; k < nb; k++) begin
      lat = 1;
      while (!send && lat < 64) begin
        tick();
        lat++;
      end
      chk(k == 0 ? "hdr_lat" : "ack_lat", lat, 2);
      if (k + 1 == abort_at) begin
        tick();
        rst = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b1;
        quiet("abort_quiet", 30);
        return;
      end
      if (coinc) begin
        transmit_done = 1'b1;
        tick();
        transmit_done = 1'b0;
      end
      d = (dly < 0) ? int'($urandom_range(1, 6)) : dly;
      for (int i = 0; i < d; i++) begin
        if (revalid && i == 0) valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
      end
      transmit_done = 1'b1;
      tick();
      transmit_done = 1'b0;
    end
    chk("done_lat", done, 1);
    chk("done_no_send", send, 0);
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NB-1:0] sol;
    int mm;
    int nn;

    // Reset held with valid_in high: nothing may be latched.
    rst = 1'b0;
    valid_in = 1'b1;
    solution = '1;
    m = 4'd11;
    n = 4'd11;
    repeat (3) tick();
    chk("rst_send", send, 0);
    chk("rst_done", done, 0);
    chk("rst_byte", byte_out, 0);
    valid_in = 1'b0;
    rst = 1'b1;
    quiet("rst_idle", 4);
    chk("rst_byte_after", byte_out, 0);

    // 2x3 board with stale coincident acknowledges.
    sol = '0;
    sol[0] = 1'b1;
    sol[2] = 1'b1;
    sol[12] = 1'b1;
    bytes = '{8'h23, 8'h00, 8'h05, 8'h00, 8'h02};
    run_board(sol, 2, 3, 2, 1'b1, 1'b0, 0);

    // 11x11 all ones, acknowledge 10 cycles after each send.
    bytes.delete();
    bytes.push_back(8'hBB);
    for (int r = 0; r < 11; r++) begin
      bytes.push_back(8'h07);
      bytes.push_back(8'hFF);
    end
    run_board('1, 11, 11, 10, 1'b0, 1'b0, 0);

    // Empty board.
    run_board('1, 0, 5, 1, 1'b0, 1'b0, 0);

    // Repeated valid_in mid-transfer, then a stray acknowledge in IDLE.
    sol = {$urandom, $urandom, $urandom, $urandom};
    model(sol, 5, 7);
    run_board(sol, 5, 7, -1, 1'b0, 1'b1, 0);
    transmit_done = 1'b1;
    tick();
    transmit_done = 1'b0;
    quiet("stray_ack", 6);

    // Abort after the third byte, then restart cleanly.
    sol = {$urandom, $urandom, $urandom, $urandom};
    model(sol, 11, 11);
    run_board(sol, 11, 11, 3, 1'b0, 1'b0, 3);
    sol = {$urandom, $urandom, $urandom, $urandom};
    model(sol, 4, 9);
    run_board(sol, 4, 9, -1, 1'b0, 1'b0, 0);

    // Random boards.
    for (int i = 0; i < 20; i++) begin
      sol = {$urandom, $urandom, $urandom, $urandom};
      mm = int'($urandom_range(1, 11));
      nn = int'($urandom_range(1, 11));
      model(sol, mm, nn);
      run_board(sol, mm, nn, -1, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    quiet("tail_idle", 5);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
